inst_encoder: RTL
=================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: width of the output word-address counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 clr  input  1  synchronous flush of buffer and address counter.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  encoder can accept a request this cycle.
REQ-007 in_type  input  3  instruction class: R=0, I=1, B=2, J=3, U=4.
REQ-008 in_func  input  5  ALU function: ADD=0, SUB=1, SLL=2, SLT=3, XOR=4, SRL=5, SRA=6, OR=7, AND=8, ADDI=9, ANDI=10, ORI=11, XORI=12, SLLI=13, SRLI=14, SRAI=15, SLTI=16, EQL=17, LT=18, GE=19.
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-010 in_imm  input  32  immediate, byte offset for B/J.
REQ-011 out_valid  output  1  encoded word available.
REQ-012 out_ready  input  1  consumer takes the word.
REQ-013 out_word  output  32  RV32I machine word.
REQ-014 out_err  output  1  request was an illegal class/function pair.
REQ-015 out_addr  output  ADDR_W  word address assigned to out_word.

Function
REQ-016 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-017 Output buffer: 2-entry FIFO of {word, err, addr}; out_valid = (count != 0); head entry drives out_word/out_err/out_addr.
REQ-018 in_ready = (count < 2), driven from registered state only; no combinational path from out_ready or in_valid.
REQ-019 Simultaneous push and pop at count=2 is impossible (in_ready low); at count 1, push and pop together leave count 1.
REQ-020 Latency: request accepted at edge N with empty buffer -> out_valid high after edge N, word visible in cycle N+1.
REQ-021 Entries leave in acceptance order; held stable while out_valid && !out_ready.
REQ-022 Address counter: assigned to each accepted request, then incremented by 1; wraps from 2^ADDR_W-1 to 0; illegal requests still consume an address.
REQ-023 R (opcode 0110011): legal funcs ADD..AND; funct3 per ADD/SUB=000, SLL=001, SLT=010, XOR=100, SRL/SRA=101, OR=110, AND=111; funct7=0100000 for SUB/SRA, else 0000000.
REQ-024 I (opcode 0010011): legal funcs ADDI..SLTI; funct3 ADDI=000, SLTI=010, XORI=100, ORI=110, ANDI=111, SLLI=001, SRLI/SRAI=101; imm[11:0] in bits 31:20, except shifts: bits 31:25 = 0100000 for SRAI else 0000000, bits 24:20 = in_imm[4:0], in_imm[11:5] ignored.
REQ-025 B (opcode 1100011): legal funcs EQL->funct3 000, LT->100, GE->101; standard B layout from in_imm[12:1]; in_imm[0] ignored; rd unused.
REQ-026 J (opcode 1101111, JAL): in_func ignored; rd and in_imm[20:1] in standard J layout; in_imm[0] ignored.
REQ-027 U (opcode 0110111, LUI): in_func ignored; rd and in_imm[31:12].
REQ-028 Illegal pair (func outside class's legal set, or in_type 5-7, or in_func > 19): out_word = 0x00000013, out_err = 1; otherwise out_err = 0.
REQ-029 clr: empties FIFO, address counter to 0; clr wins over any same-cycle push or pop (request dropped).

Reset
REQ-030 On rst assertion, immediately: count=0, address=0, out_valid=0, out_word=0, out_err=0, out_addr=0, in_ready=0 while rst high.
REQ-031 After rst release, in_ready=1 on the first clock edge onward; reset mid-transfer discards all buffered entries.

Verification
REQ-032 R ADD rd=1 rs1=2 rs2=3, then SUB rd=5 rs1=6 rs2=7 -> 0x003100B3 addr 0, 0x407302B3 addr 1, err 0.
REQ-033 I ADDI rd=1 rs1=0 imm=0xFFFFFFFF -> 0xFFF00093; SRAI rd=2 rs1=2 imm=3 -> 0x40315113.
REQ-034 B EQL rs1=1 rs2=2 imm=8 -> 0x00208463; R class with func ADDI -> 0x00000013, err 1, address still advances.
REQ-035 out_ready=0, offer 3 requests back-to-back -> two accepted, in_ready=0, third held; raise out_ready -> words drain in order, third accepted next cycle.
REQ-036 Address 255 (ADDR_W=8) accepted -> next out_addr 0; assert clr with buffer full and in_valid high -> out_valid=0, next accepted request gets addr 0.
REQ-037 Assert rst asynchronously between edges with 2 entries buffered -> out_valid and in_ready drop without clock edge; after release, first request gets addr 0.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder with a 2-entry output buffer.
// Each accepted request is tagged with a sequential word address.
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [4:0]        in_func,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic              out_err,
    output logic [ADDR_W-1:0] out_addr
);

    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_B = 3'd2;
    localparam logic [2:0] T_J = 3'd3;
    localparam logic [2:0] T_U = 3'd4;

    localparam logic [4:0] F_ADD  = 5'd0;
    localparam logic [4:0] F_SUB  = 5'd1;
    localparam logic [4:0] F_SLL  = 5'd2;
    localparam logic [4:0] F_SLT  = 5'd3;
    localparam logic [4:0] F_XOR  = 5'd4;
    localparam logic [4:0] F_SRL  = 5'd5;
    localparam logic [4:0] F_SRA  = 5'd6;
    localparam logic [4:0] F_OR   = 5'd7;
    localparam logic [4:0] F_AND  = 5'd8;
    localparam logic [4:0] F_ADDI = 5'd9;
    localparam logic [4:0] F_ANDI = 5'd10;
    localparam logic [4:0] F_ORI  = 5'd11;
    localparam logic [4:0] F_XORI = 5'd12;
    localparam logic [4:0] F_SLLI = 5'd13;
    localparam logic [4:0] F_SRLI = 5'd14;
    localparam logic [4:0] F_SRAI = 5'd15;
    localparam logic [4:0] F_SLTI = 5'd16;
    localparam logic [4:0] F_EQL  = 5'd17;
    localparam logic [4:0] F_LT   = 5'd18;
    localparam logic [4:0] F_GE   = 5'd19;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [6:0]  F7_ALT   = 7'b0100000;

    logic [31:0]       enc_word;
    logic              enc_err;
    logic [2:0]        f3;
    logic [6:0]        f7;

    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              rdy;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       word_q [2];
    logic              err_q  [2];
    logic [ADDR_W-1:0] addr_q [2];

    logic              push;
    logic              pop;

    // Encode the incoming request; illegal pairs become a flagged NOP.
    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
        f3       = 3'b000;
        f7       = 7'b0000000;
        if (in_func <= F_GE) begin
            case (in_type)
                T_R: begin
                    if (in_func <= F_AND) begin
                        case (in_func)
                            F_ADD:   f3 = 3'b000;
                            F_SUB:   f3 = 3'b000;
                            F_SLL:   f3 = 3'b001;
                            F_SLT:   f3 = 3'b010;
                            F_XOR:   f3 = 3'b100;
                            F_SRL:   f3 = 3'b101;
                            F_SRA:   f3 = 3'b101;
                            F_OR:    f3 = 3'b110;
                            default: f3 = 3'b111;
                        endcase
                        if (in_func == F_SUB || in_func == F_SRA) begin
                            f7 = F7_ALT;
                        end
                        enc_word = {f7, in_rs2, in_rs1, f3, in_rd, OP_R};
                        enc_err  = 1'b0;
                    end
                end
                T_I: begin
                    if (in_func >= F_ADDI && in_func <= F_SLTI) begin
                        case (in_func)
                            F_ADDI:  f3 = 3'b000;
                            F_ANDI:  f3 = 3'b111;
                            F_ORI:   f3 = 3'b110;
                            F_XORI:  f3 = 3'b100;
                            F_SLLI:  f3 = 3'b001;
                            F_SRLI:  f3 = 3'b101;
                            F_SRAI:  f3 = 3'b101;
                            default: f3 = 3'b010;
                        endcase
                        if (in_func == F_SLLI || in_func == F_SRLI ||
                            in_func == F_SRAI) begin
                            // Shifts carry only a 5-bit shamt; upper field
                            // selects arithmetic vs logical.
                            if (in_func == F_SRAI) begin
                                f7 = F7_ALT;
                            end
                            enc_word = {f7, in_imm[4:0], in_rs1, f3,
                                        in_rd, OP_I};
                        end else begin
                            enc_word = {in_imm[11:0], in_rs1, f3,
                                        in_rd, OP_I};
                        end
                        enc_err = 1'b0;
                    end
                end
                T_B: begin
                    if (in_func >= F_EQL) begin
                        case (in_func)
                            F_EQL:   f3 = 3'b000;
                            F_LT:    f3 = 3'b100;
                            default: f3 = 3'b101;
                        endcase
                        enc_word = {in_imm[12], in_imm[10:5], in_rs2,
                                    in_rs1, f3, in_imm[4:1], in_imm[11],
                                    OP_B};
                        enc_err  = 1'b0;
                    end
                end
                T_J: begin
                    enc_word = {in_imm[20], in_imm[10:1], in_imm[11],
                                in_imm[19:12], in_rd, OP_JAL};
                    enc_err  = 1'b0;
                end
                T_U: begin
                    enc_word = {in_imm[31:12], in_rd, OP_LUI};
                    enc_err  = 1'b0;
                end
                default: begin
                    enc_word = NOP_WORD;
                    enc_err  = 1'b1;
                end
            endcase
        end
    end

    // Handshake terms come only from registered state and the inputs.
    always_comb begin
        in_ready  = rdy && (count < 2'd2);
        out_valid = (count != 2'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Head entry of the buffer drives the output side.
    always_comb begin
        out_word = word_q[rd_ptr];
        out_err  = err_q[rd_ptr];
        out_addr = addr_q[rd_ptr];
    end

    // Buffer occupancy, pointers, address counter and ready enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            addr_cnt <= '0;
            rdy      <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (clr) begin
                count    <= 2'd0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                addr_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr   <= ~wr_ptr;
                    addr_cnt <= addr_cnt + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Buffer storage; a flush drops any same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                word_q[i] <= '0;
                err_q[i]  <= 1'b0;
                addr_q[i] <= '0;
            end
        end else if (push && !clr) begin
            word_q[wr_ptr] <= enc_word;
            err_q[wr_ptr]  <= enc_err;
            addr_q[wr_ptr] <= addr_cnt;
        end
    end

endmodule
